// File: rtl/mult_div_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
// Optional feature macro: MULTDIV_UNSIGNED_EN (adds MULTU/DIVU support).
package mult_div_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ITER_COUNT = 32;

  // Booth recoding of {Q[0], Q[-1]}
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    DIV_FIX,
    WRITE,
    DZ
  } md_state_e;

endpackage

// File: rtl/md_step_core.sv
// Combinational single-iteration datapath: one radix-2 Booth step or one
// restoring-divide step, chosen by div_mode_i. Holds no state.
module md_step_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              div_mode_i,
  input  logic [DATA_W+1:0] acc_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic              qm1_i,
  input  logic [DATA_W+1:0] m_i,
  output logic [DATA_W+1:0] acc_o,
  output logic [DATA_W-1:0] q_o,
  output logic              qm1_o
);
  import mult_div_pkg::*;

  logic [1:0]        sel;
  logic [DATA_W+1:0] sum;
  logic [DATA_W:0]   rs;
  logic [DATA_W+1:0] trial;

  // Booth add/sub, or shift-and-trial-subtract, then pick per mode
  always_comb begin
    sel = {q_i[0], qm1_i};
    case (sel)
      BOOTH_ADD:              sum = acc_i + m_i;
      BOOTH_SUB:              sum = acc_i - m_i;
      BOOTH_NOP0, BOOTH_NOP1: sum = acc_i;
      default:                sum = acc_i;
    endcase

    // Remainder after shifting {R,Q} left by one; R always stays below the divisor
    rs    = {acc_i[DATA_W-1:0], q_i[DATA_W-1]};
    trial = {1'b0, rs} - {1'b0, m_i[DATA_W:0]};

    if (div_mode_i) begin
      acc_o = trial[DATA_W+1] ? {1'b0, rs} : trial;
      q_o   = {q_i[DATA_W-2:0], ~trial[DATA_W+1]};
      qm1_o = qm1_i;
    end else begin
      acc_o = {sum[DATA_W+1], sum[DATA_W+1:1]};
      q_o   = {sum[0], q_i[DATA_W-1:1]};
      qm1_o = q_i[0];
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multicycle MULT/DIV sequencer with Hi/Lo result registers.
// Optional feature macro: MULTDIV_UNSIGNED_EN (adds is_unsigned for MULTU/DIVU).
module mult_div_sequencer #(
  parameter int unsigned DATA_W = mult_div_pkg::DATA_W,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              div_start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic              is_unsigned,
`endif
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  import mult_div_pkg::*;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W+1:0] acc_q, acc_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              qm1_q, qm1_d;
  logic [DATA_W+1:0] m_q, m_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              div_q, div_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  logic              uns_in;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W+1:0] step_acc;
  logic [DATA_W-1:0] step_q;
  logic              step_qm1;

`ifdef MULTDIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  // Sign handling at start: unsigned ops see every operand as non-negative
  assign a_neg = op_a[DATA_W-1] & ~uns_in;
  assign b_neg = op_b[DATA_W-1] & ~uns_in;
  assign a_mag = a_neg ? (-op_a) : op_a;
  assign b_mag = b_neg ? (-op_b) : op_b;

  md_step_core #(
    .DATA_W(DATA_W)
  ) u_step (
    .div_mode_i(state_q == DIV_RUN),
    .acc_i     (acc_q),
    .q_i       (q_q),
    .qm1_i     (qm1_q),
    .m_i       (m_q),
    .acc_o     (step_acc),
    .q_o       (step_q),
    .qm1_o     (step_qm1)
  );

  // State, working and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      uns_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      uns_q   <= uns_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    uns_d   = uns_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mult_start) begin
          state_d = MULT_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          q_d     = op_b;
          qm1_d   = 1'b0;
          m_d     = {{2{a_neg}}, op_a};
          div_d   = 1'b0;
          uns_d   = uns_in;
        end else if (div_start) begin
          if (op_b != '0) begin
            state_d = DIV_RUN;
            cnt_d   = '0;
            acc_d   = '0;
            q_d     = a_mag;
            qm1_d   = 1'b0;
            m_d     = {2'b00, b_mag};
            sa_d    = a_neg;
            sb_d    = b_neg;
            div_d   = 1'b1;
            uns_d   = uns_in;
          end else begin
            state_d = DZ;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        qm1_d = step_qm1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = (state_q == DIV_RUN) ? DIV_FIX : WRITE;
        end
      end
      DIV_FIX: begin
        if (!uns_q && (sa_q ^ sb_q)) q_d = -q_q;
        if (!uns_q && sa_q) acc_d = {2'b00, -acc_q[DATA_W-1:0]};
        state_d = WRITE;
      end
      WRITE: begin
        // Unsigned MULT: Q[-1] now holds the multiplier MSB; adding the multiplicand
        // to Hi stands in for the 33rd Booth step of the zero-extended multiplier.
        hi_d    = acc_q[DATA_W-1:0] +
                  ((!div_q && uns_q && qm1_q) ? m_q[DATA_W-1:0] : '0);
        lo_d    = q_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        dz_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == MULT_RUN) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_unsigned;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  int          done_edge;
  int          done_cnt;
  int          dz_edge;
  int          dz_cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [0:45] busy_hist;

  mult_div_sequencer #(
    .DATA_W(32),
    .CNT_W (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one start at edge 0 and observe edges 1..45; optional div_start at edge inj
  task automatic run_op(input logic ms, input logic ds, input logic [31:0] a,
                        input logic [31:0] b, input int inj);
    done_edge = -1; done_cnt = 0; dz_edge = -1; dz_cnt = 0;
    res_hi = 'x; res_lo = 'x;
    busy_hist = '0;
    mult_start = ms; div_start = ds; op_a = a; op_b = b;
    @(posedge clk); #1;
    mult_start = 1'b0; div_start = 1'b0;
    busy_hist[0] = busy;
    for (int k = 1; k <= 45; k++) begin
      if (k == inj) begin
        div_start = 1'b1; op_a = 32'd9; op_b = 32'd1;
      end
      @(posedge clk); #1;
      div_start = 1'b0;
      busy_hist[k] = busy;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) begin done_edge = k; res_hi = hi; res_lo = lo; end
      end
      if (div_by_zero === 1'b1) begin
        dz_cnt++;
        if (dz_edge < 0) begin dz_edge = k; res_hi = hi; res_lo = lo; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mult_start = 1'b0; div_start = 1'b0;
    op_a = '0; op_b = '0; is_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    n_checks++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_basic();
    run_op(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
    n_checks++;
    if (done_edge !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", done_edge); end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL mult_done_count: got %0d expected 1", done_cnt); end
    n_checks++;
    if (res_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_7x-3_hi: got %h expected ffffffff", res_hi); end
    n_checks++;
    if (res_lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_7x-3_lo: got %h expected ffffffeb", res_lo); end
    n_checks++;
    if (dz_cnt !== 0) begin n_fail++; $display("FAIL mult_no_dz: got %0d expected 0", dz_cnt); end
  endtask

  task automatic test_div_signed();
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    n_checks++;
    if (done_edge !== 34) begin n_fail++; $display("FAIL div_latency: got %0d expected 34", done_edge); end
    n_checks++;
    if (res_lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_-7/2_lo: got %h expected fffffffd", res_lo); end
    n_checks++;
    if (res_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_-7/2_hi: got %h expected ffffffff", res_hi); end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL div_done_count: got %0d expected 1", done_cnt); end

    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0);
    n_checks++;
    if ({res_hi, res_lo} !== {32'd2, 32'hFFFF_FFF2}) begin
      n_fail++; $display("FAIL div_100/-7: got %h expected 00000002fffffff2", {res_hi, res_lo});
    end
  endtask

  task automatic test_div_overflow();
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    n_checks++;
    if (res_lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", res_lo); end
    n_checks++;
    if (res_hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", res_hi); end
    n_checks++;
    if (dz_cnt !== 0) begin n_fail++; $display("FAIL div_ovf_no_dz: got %0d expected 0", dz_cnt); end
  endtask

  task automatic test_mult_extremes();
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    n_checks++;
    if ({res_hi, res_lo} !== 64'h4000_0000_0000_0000) begin
      n_fail++; $display("FAIL mult_min_sq: got %h expected 4000000000000000", {res_hi, res_lo});
    end
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    n_checks++;
    if ({res_hi, res_lo} !== 64'h3FFF_FFFF_0000_0001) begin
      n_fail++; $display("FAIL mult_max_sq: got %h expected 3fffffff00000001", {res_hi, res_lo});
    end
    n_checks++;
    if (busy_hist[0:32] !== 33'h1_FFFF_FFFE) begin
      n_fail++; $display("FAIL mult_busy_window: got %b expected %b", busy_hist[0:32], 33'h1_FFFF_FFFE);
    end
  endtask

  task automatic test_div_by_zero();
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    n_checks++;
    if (dz_edge !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", dz_edge); end
    n_checks++;
    if (dz_cnt !== 1) begin n_fail++; $display("FAIL dz_pulse_count: got %0d expected 1", dz_cnt); end
    n_checks++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL dz_no_done: got %0d expected 0", done_cnt); end
    n_checks++;
    if ({hi, lo} !== 64'h3FFF_FFFF_0000_0001) begin
      n_fail++; $display("FAIL dz_hilo_kept: got %h expected 3fffffff00000001", {hi, lo});
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 10);
    n_checks++;
    if (done_edge !== 33) begin n_fail++; $display("FAIL prio_latency: got %0d expected 33", done_edge); end
    n_checks++;
    if ({res_hi, res_lo} !== {32'd0, 32'd12}) begin
      n_fail++; $display("FAIL prio_mult_wins: got %h expected 000000000000000c", {res_hi, res_lo});
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_ignored: got %0d dones expected 1", done_cnt); end
    n_checks++;
    if (dz_cnt !== 0) begin n_fail++; $display("FAIL prio_no_dz: got %0d expected 0", dz_cnt); end
  endtask

  task automatic test_reset_abort();
    int late_done;
    mult_start = 1'b1; op_a = 32'h1234_5678; op_b = 32'd3;
    @(posedge clk); #1;
    mult_start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    @(posedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++; $display("FAIL abort_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    n_checks++;
    if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    late_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || div_by_zero === 1'b1) late_done++;
    end
    n_checks++;
    if (late_done !== 0) begin n_fail++; $display("FAIL abort_no_pulse: got %0d expected 0", late_done); end

    run_op(1'b1, 1'b0, 32'd2, 32'd2, 0);
    n_checks++;
    if (done_edge !== 33 || {res_hi, res_lo} !== 64'd4) begin
      n_fail++; $display("FAIL after_abort_2x2: got edge %0d result %h expected edge 33 result 4",
                         done_edge, {res_hi, res_lo});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult_basic();
    test_div_signed();
    test_div_overflow();
    test_mult_extremes();
    test_div_by_zero();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
